// File: rtl/router_ingress_if.sv
// router_ingress_if: AXI4 AW/W/AR request channels between a master and a
// router input port. The master modport drives valid/payload and receives
// ready; the slave modport is the mirror image.
//   aw*: write address channel (addr, len, size, burst)
//   w* : write data channel (data, strb, last)
//   ar*: read address channel (addr, len, size, burst)
interface router_ingress_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        output arvalid, araddr, arlen, arsize, arburst,
        input  arready
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        input  arvalid, araddr, arlen, arsize, arburst,
        output arready
    );
endinterface

// File: rtl/router_ingress_buf.sv
// router_ingress_buf: per-port ingress buffer in front of a router input.
// Registered AW/AR/W FIFOs decouple the master from the crossbar. W beats
// are only released once their AW has been handed to the router; wlast is
// regenerated from the accepted awlen and master wlast mismatches are counted.
//   clk, rst_n : clock, asynchronous active-low reset
//   s          : upstream AXI request channels (slave modport)
//   m          : downstream AXI request channels to the router (master modport)
//   err_wlast  : sticky, a master wlast mismatch was seen
//   err_cnt    : saturating count of mismatched beats

// Synchronous FIFO with registered pointers and occupancy count. The head is
// forced to zero while empty so idle/reset payloads read as zero.
module ingress_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign dout  = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end
endmodule

module router_ingress_buf #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 32,
    parameter int AFIFO_DEPTH = 4,
    parameter int WFIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    router_ingress_if.slave        s,
    router_ingress_if.master       m,
    output logic                   err_wlast,
    output logic [7:0]             err_cnt
);
    localparam int A_W = ADDR_W + 13;            // {addr, len, size, burst}
    localparam int W_W = DATA_W + DATA_W/8 + 1;  // {data, strb, last}

    logic           aw_full, aw_empty, ar_full, ar_empty;
    logic           w_full, w_empty, l_full, l_empty;
    logic [A_W-1:0] aw_head, ar_head;
    logic [W_W-1:0] w_head;
    logic [7:0]     l_head;
    logic           aw_push, aw_pop, ar_push, ar_pop, w_push, w_pop, l_pop;
    logic [7:0]     beat_cnt;
    logic           wlast_gen;

    // Upstream ready looks only at registered occupancy.
    assign s.awready = !aw_full;
    assign s.wready  = !w_full;
    assign s.arready = !ar_full;

    assign aw_push = s.awvalid && !aw_full;
    assign w_push  = s.wvalid  && !w_full;
    assign ar_push = s.arvalid && !ar_full;

    // AW is held back while LQ cannot record its length.
    assign m.awvalid = !aw_empty && !l_full;
    assign aw_pop    = m.awvalid && m.awready;
    assign m.awaddr  = aw_head[A_W-1 -: ADDR_W];
    assign m.awlen   = aw_head[12:5];
    assign m.awsize  = aw_head[4:2];
    assign m.awburst = aw_head[1:0];

    assign m.arvalid = !ar_empty;
    assign ar_pop    = m.arvalid && m.arready;
    assign m.araddr  = ar_head[A_W-1 -: ADDR_W];
    assign m.arlen   = ar_head[12:5];
    assign m.arsize  = ar_head[4:2];
    assign m.arburst = ar_head[1:0];

    // A W beat only leaves once LQ holds the length of an accepted AW.
    assign wlast_gen = (beat_cnt == l_head);
    assign m.wvalid  = !w_empty && !l_empty;
    assign w_pop     = m.wvalid && m.wready;
    assign l_pop     = w_pop && wlast_gen;
    assign m.wdata   = w_head[W_W-1 -: DATA_W];
    assign m.wstrb   = w_head[DATA_W/8:1];
    assign m.wlast   = wlast_gen;

    ingress_fifo #(.W(A_W), .DEPTH(AFIFO_DEPTH)) u_awq (
        .clk, .rst_n, .push(aw_push),
        .din({s.awaddr, s.awlen, s.awsize, s.awburst}),
        .pop(aw_pop), .dout(aw_head), .full(aw_full), .empty(aw_empty)
    );

    ingress_fifo #(.W(A_W), .DEPTH(AFIFO_DEPTH)) u_arq (
        .clk, .rst_n, .push(ar_push),
        .din({s.araddr, s.arlen, s.arsize, s.arburst}),
        .pop(ar_pop), .dout(ar_head), .full(ar_full), .empty(ar_empty)
    );

    ingress_fifo #(.W(W_W), .DEPTH(WFIFO_DEPTH)) u_wq (
        .clk, .rst_n, .push(w_push),
        .din({s.wdata, s.wstrb, s.wlast}),
        .pop(w_pop), .dout(w_head), .full(w_full), .empty(w_empty)
    );

    // Burst lengths of AWs already handed to the router, oldest first.
    ingress_fifo #(.W(8), .DEPTH(AFIFO_DEPTH)) u_lq (
        .clk, .rst_n, .push(aw_pop), .din(m.awlen),
        .pop(l_pop), .dout(l_head), .full(l_full), .empty(l_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            err_wlast <= 1'b0;
            err_cnt   <= '0;
        end else if (w_pop) begin
            beat_cnt <= wlast_gen ? 8'd0 : beat_cnt + 8'd1;
            // Stored master wlast sits in the LSB of the W entry.
            if (w_head[0] != wlast_gen) begin
                err_wlast <= 1'b1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
        end
    end
endmodule
